instruction_fetch_unit: RTL

Fetch stage of the 5-stage MIPS pipeline. Owns the program counter and issues word reads to instruction memory over a req/gnt/rvalid port. Presents one instruction and its PC+4 per transfer to the IF/ID pipeline register. Honours back-pressure (stall) from the hazard unit and redirects (branch/jump) from later stages, discarding any in-flight fetch.

---
 rtl/instruction_fetch_unit.sv | 98 +++++++++
 1 files changed

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC, issues req/gnt/rvalid word reads, and feeds a one-deep
// output slot plus a one-entry pending buffer to the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instOut,
    output logic [31:0] pcOut,
    output logic        inst_valid
);

    typedef enum logic [1:0] {REQ, WAIT, FULL, DRAIN} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] fetch_pc;
    logic [31:0] pend_inst;
    logic [31:0] pend_pc;
    logic        consume;

    assign consume   = inst_valid & ~stall;
    // Moore outputs: decoded only from state and pc, never from inputs.
    assign imem_req  = (state == REQ);
    assign imem_addr = pc;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= REQ;
            pc         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            pend_inst  <= 32'd0;
            pend_pc    <= 32'd0;
            instOut    <= 32'd0;
            pcOut      <= 32'd0;
            inst_valid <= 1'b0;
        end else if (redirect) begin
            // A consume this edge already happened in IF/ID; just flush our copy.
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
            case (state)
                REQ:     state <= imem_gnt    ? DRAIN : REQ;
                WAIT:    state <= imem_rvalid ? REQ   : DRAIN;
                FULL:    state <= REQ;
                DRAIN:   state <= imem_rvalid ? REQ   : DRAIN;
                default: state <= REQ;
            endcase
        end else begin
            if (consume)
                inst_valid <= 1'b0;
            case (state)
                REQ: begin
                    if (imem_gnt) begin
                        fetch_pc <= pc;
                        pc       <= pc + 32'd4;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (!inst_valid || consume) begin
                            instOut    <= imem_rdata;
                            pcOut      <= fetch_pc + 32'd4;
                            inst_valid <= 1'b1;
                            state      <= REQ;
                        end else begin
                            pend_inst <= imem_rdata;
                            pend_pc   <= fetch_pc + 32'd4;
                            state     <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (consume) begin
                        instOut    <= pend_inst;
                        pcOut      <= pend_pc;
                        inst_valid <= 1'b1;
                        state      <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid)
                        state <= REQ;
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule
